// File: rtl/spi_cfg_arbiter.sv
// spi_cfg_arbiter: shares one SPI register-write master between NUM_REQ
// configuration requesters. Each requester can hold one queued transaction;
// queued transactions are granted round-robin, issued to the SPI master one
// at a time, and completed with a per-requester done pulse plus read data.
module spi_cfg_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned DONE_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    // Requester side
    input  logic [NUM_REQ-1:0]     i_req_send,
    input  logic [6*NUM_REQ-1:0]   i_req_reg,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_rw,
    output logic [NUM_REQ-1:0]     o_req_busy,
    output logic [NUM_REQ-1:0]     o_req_done,
    output logic [NUM_REQ-1:0]     o_req_overrun,
    output logic [7:0]             o_rd_data,
    // SPI master side
    output logic [5:0]             o_spi_reg,
    output logic [7:0]             o_spi_data_in,
    output logic                   o_spi_rw,
    output logic                   o_spi_send,
    input  logic                   i_spi_done,
    input  logic [7:0]             i_spi_data_out,
    output logic                   o_spi_timeout
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitFall,
        StWaitRise
    } state_t;

    // Per-requester queue slot
    logic [NUM_REQ-1:0]        r_pending;
    logic [NUM_REQ-1:0][5:0]   r_hold_reg;
    logic [NUM_REQ-1:0][7:0]   r_hold_data;
    logic [NUM_REQ-1:0]        r_hold_rw;

    // Arbitration / sequencing state
    state_t                    r_state;
    state_t                    w_state_next;
    logic [IdxW-1:0]           r_winner;
    logic [IdxW-1:0]           r_last_grant;
    logic [CntW-1:0]           r_cnt;

    // Registered outputs
    logic [5:0]                r_spi_reg;
    logic [7:0]                r_spi_data_in;
    logic                      r_spi_rw;
    logic                      r_spi_send;
    logic                      r_spi_timeout;
    logic [NUM_REQ-1:0]        r_req_done;
    logic [NUM_REQ-1:0]        r_req_overrun;
    logic [7:0]                r_rd_data;

    // Combinational helpers
    logic [NUM_REQ-1:0]        w_accept;
    logic [NUM_REQ-1:0]        w_overrun;
    logic [NUM_REQ-1:0]        w_clear;
    logic [NUM_REQ-1:0]        w_pending_next;
    logic [NUM_REQ-1:0]        w_win_onehot;
    logic [NUM_REQ-1:0]        w_done_next;
    logic [IdxW:0]             w_cand;
    logic [IdxW-1:0]           w_grant;
    logic                      w_grant_valid;
    logic                      w_load;
    logic                      w_timeout_next;
    logic                      w_rd_capture;
    logic                      w_last_grant_upd;
    logic                      w_cnt_run;

    assign w_win_onehot = NUM_REQ'(1) << r_winner;

    // Slot bookkeeping: a send is accepted if the slot is free or being freed
    // on this very edge; otherwise it is dropped and flagged as an overrun.
    always_comb begin
        w_accept       = i_req_send & (~r_pending | w_clear);
        w_overrun      = i_req_send & r_pending & ~w_clear;
        w_pending_next = (r_pending & ~w_clear) | w_accept;
    end

    // Round-robin search starting one past the last completed grant
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_cand        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last_grant} + (IdxW+1)'(k);
            if (w_cand >= (IdxW+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IdxW+1)'(NUM_REQ);
            end
            if (!w_grant_valid && r_pending[w_cand[IdxW-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant       = w_cand[IdxW-1:0];
            end
        end
    end

    // FSM next-state and per-cycle control decode
    always_comb begin
        w_state_next     = r_state;
        w_load           = 1'b0;
        w_clear          = '0;
        w_done_next      = '0;
        w_timeout_next   = 1'b0;
        w_rd_capture     = 1'b0;
        w_last_grant_upd = 1'b0;
        w_cnt_run        = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Skip the cycle carrying a done pulse so a requester that
                // resends on its done pulse competes in the next arbitration.
                if (w_grant_valid && (r_req_done == '0)) begin
                    w_load       = 1'b1;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_cnt_run    = 1'b1;
                w_state_next = StWaitFall;
            end
            StWaitFall: begin
                w_cnt_run = 1'b1;
                if (!i_spi_done) begin
                    w_state_next = StWaitRise;
                end else if (r_cnt == CntW'(DONE_TIMEOUT - 1)) begin
                    w_timeout_next = 1'b1;
                    w_done_next    = w_win_onehot;
                    w_clear        = w_win_onehot;
                    w_state_next   = StIdle;
                end
            end
            StWaitRise: begin
                if (i_spi_done) begin
                    w_rd_capture     = 1'b1;
                    w_done_next      = w_win_onehot;
                    w_clear          = w_win_onehot;
                    w_last_grant_upd = 1'b1;
                    w_state_next     = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture accepted sends into the per-requester slots
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending   <= '0;
            r_hold_reg  <= '0;
            r_hold_data <= '0;
            r_hold_rw   <= '0;
        end else begin
            r_pending <= w_pending_next;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_hold_reg[i]  <= i_req_reg[6*i +: 6];
                    r_hold_data[i] <= i_req_data[8*i +: 8];
                    r_hold_rw[i]   <= i_req_rw[i];
                end
            end
        end
    end

    // Latch the winner and its transaction onto the SPI master inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner      <= '0;
            r_last_grant  <= IdxW'(NUM_REQ - 1);
            r_spi_reg     <= '0;
            r_spi_data_in <= '0;
            r_spi_rw      <= 1'b0;
        end else begin
            if (w_load) begin
                r_winner      <= w_grant;
                r_spi_reg     <= r_hold_reg[w_grant];
                r_spi_data_in <= r_hold_data[w_grant];
                r_spi_rw      <= r_hold_rw[w_grant];
            end
            if (w_last_grant_upd) begin
                r_last_grant <= r_winner;
            end
        end
    end

    // Timeout counter: zero in ISSUE, counts through WAIT_FALL
    always_ff @(posedge clk) begin
        if (reset || w_load) begin
            r_cnt <= '0;
        end else if (w_cnt_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Single-cycle pulses and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spi_send    <= 1'b0;
            r_spi_timeout <= 1'b0;
            r_req_done    <= '0;
            r_req_overrun <= '0;
            r_rd_data     <= '0;
        end else begin
            r_spi_send    <= w_load;
            r_spi_timeout <= w_timeout_next;
            r_req_done    <= w_done_next;
            r_req_overrun <= w_overrun;
            if (w_rd_capture) begin
                r_rd_data <= i_spi_data_out;
            end
        end
    end

    assign o_req_busy    = r_pending;
    assign o_req_done    = r_req_done;
    assign o_req_overrun = r_req_overrun;
    assign o_rd_data     = r_rd_data;
    assign o_spi_reg     = r_spi_reg;
    assign o_spi_data_in = r_spi_data_in;
    assign o_spi_rw      = r_spi_rw;
    assign o_spi_send    = r_spi_send;
    assign o_spi_timeout = r_spi_timeout;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Bench for spi_cfg_arbiter: a behavioural SPI master model plus a scoreboard
// of expected SPI issues and expected completions.
module tb_spi_cfg_arbiter;

    localparam int unsigned NUM_REQ      = 3;
    localparam int unsigned DONE_TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     i_req_send;
    logic [6*NUM_REQ-1:0]   i_req_reg;
    logic [8*NUM_REQ-1:0]   i_req_data;
    logic [NUM_REQ-1:0]     i_req_rw;
    logic [NUM_REQ-1:0]     o_req_busy;
    logic [NUM_REQ-1:0]     o_req_done;
    logic [NUM_REQ-1:0]     o_req_overrun;
    logic [7:0]             o_rd_data;
    logic [5:0]             o_spi_reg;
    logic [7:0]             o_spi_data_in;
    logic                   o_spi_rw;
    logic                   o_spi_send;
    logic                   i_spi_done;
    logic [7:0]             i_spi_data_out;
    logic                   o_spi_timeout;

    spi_cfg_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .i_req_send     (i_req_send),
        .i_req_reg      (i_req_reg),
        .i_req_data     (i_req_data),
        .i_req_rw       (i_req_rw),
        .o_req_busy     (o_req_busy),
        .o_req_done     (o_req_done),
        .o_req_overrun  (o_req_overrun),
        .o_rd_data      (o_rd_data),
        .o_spi_reg      (o_spi_reg),
        .o_spi_data_in  (o_spi_data_in),
        .o_spi_rw       (o_spi_rw),
        .o_spi_send     (o_spi_send),
        .i_spi_done     (i_spi_done),
        .i_spi_data_out (i_spi_data_out),
        .o_spi_timeout  (o_spi_timeout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [5:0] r;
        logic [7:0] d;
        logic       rw;
    } issue_t;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] rd;
        logic       tmo;
    } done_t;

    issue_t      exp_issue[$];
    done_t       exp_done[$];
    issue_t      ei;
    done_t       ed;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned ovr_total = 0;
    int unsigned last_send_cyc = 0;
    int unsigned last_done_cyc = 0;
    int unsigned rise_cyc = 0;
    int unsigned model_busy = 4;
    logic [7:0]  model_rdata = 8'h00;
    logic        model_dead = 1'b0;
    logic [7:0]  exp_last_rd = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SPI master model: drops done one cycle after a send, holds it low
    // model_busy cycles, then presents read data with done high.
    initial begin
        i_spi_done     = 1'b1;
        i_spi_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (o_spi_send && !model_dead && !reset) begin
                @(posedge clk);
                #1;
                i_spi_done = 1'b0;
                for (int k = 0; k < int'(model_busy) && !reset; k++) begin
                    @(posedge clk);
                    #1;
                end
                i_spi_data_out = model_rdata;
                i_spi_done     = 1'b1;
                rise_cyc       = cyc;
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (o_spi_send) begin
                check_eq("send_expected", 32'(exp_issue.size() != 0), 1);
                if (exp_issue.size() != 0) begin
                    ei = exp_issue.pop_front();
                    check_eq("issue_reg", 32'(o_spi_reg), 32'(ei.r));
                    check_eq("issue_data", 32'(o_spi_data_in), 32'(ei.d));
                    check_eq("issue_rw", 32'(o_spi_rw), 32'(ei.rw));
                end
                if (cyc - last_done_cyc <= 2) begin
                    check_eq("grant_gap", cyc - last_done_cyc, 2);
                end
                last_send_cyc = cyc;
            end
            if (o_req_done != '0) begin
                check_eq("done_expected", 32'(exp_done.size() != 0), 1);
                if (exp_done.size() != 0) begin
                    ed = exp_done.pop_front();
                    check_eq("done_onehot", 32'(o_req_done), 32'(1) << ed.idx);
                    check_eq("done_rd_data", 32'(o_rd_data), 32'(ed.rd));
                    check_eq("done_timeout_flag", 32'(o_spi_timeout), 32'(ed.tmo));
                    if (ed.tmo) begin
                        check_eq("timeout_latency", cyc, last_send_cyc + DONE_TIMEOUT);
                    end else begin
                        check_eq("done_latency", cyc, rise_cyc + 1);
                    end
                end
                last_done_cyc = cyc;
            end
            if (o_spi_timeout) begin
                check_eq("timeout_has_done", 32'(o_req_done != '0), 1);
            end
            ovr_total += $countones(o_req_overrun);
        end
    end

    task automatic set_req(input int unsigned idx, input logic [5:0] r, input logic [7:0] d,
                           input logic rw);
        i_req_send[idx]        = 1'b1;
        i_req_reg[6*idx +: 6]  = r;
        i_req_data[8*idx +: 8] = d;
        i_req_rw[idx]          = rw;
    endtask

    task automatic expect_txn(input int unsigned idx, input logic [5:0] r, input logic [7:0] d,
                              input logic rw, input logic [7:0] rd, input logic tmo);
        exp_issue.push_back({r, d, rw});
        exp_done.push_back({3'(idx), rd, tmo});
    endtask

    task automatic clear_sends();
        @(negedge clk);
        i_req_send = '0;
    endtask

    task automatic wait_send(output int unsigned at);
        int k = 0;
        while (!o_spi_send && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("send_seen", 32'(o_spi_send), 1);
        at = cyc;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_done.size() != 0 || o_req_busy != '0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_done_q"}, 32'(exp_done.size()), 0);
        check_eq({tag, "_issue_q"}, 32'(exp_issue.size()), 0);
        check_eq({tag, "_busy"}, 32'(o_req_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0;
        int unsigned ts;
        reset      = 1'b1;
        i_req_send = '0;
        i_req_reg  = '0;
        i_req_data = '0;
        i_req_rw   = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_req_out", 32'({o_req_busy, o_req_done, o_req_overrun}), 0);
        check_eq("rst_rd_data", 32'(o_rd_data), 0);
        check_eq("rst_spi_out",
                 32'({o_spi_reg, o_spi_data_in, o_spi_rw, o_spi_send, o_spi_timeout}), 0);

        // Round-robin: simultaneous sends from all three, then 0 and 2 again
        model_busy  = 4;
        model_rdata = 8'h10;
        @(negedge clk);
        set_req(0, 6'h04, 8'h11, 1'b0);
        set_req(1, 6'h07, 8'h22, 1'b0);
        set_req(2, 6'h08, 8'h33, 1'b0);
        expect_txn(0, 6'h04, 8'h11, 1'b0, 8'h10, 1'b0);
        expect_txn(1, 6'h07, 8'h22, 1'b0, 8'h10, 1'b0);
        expect_txn(2, 6'h08, 8'h33, 1'b0, 8'h10, 1'b0);
        clear_sends();
        check_eq("rr_busy_all", 32'(o_req_busy), 32'h7);
        drain("rr1");
        @(negedge clk);
        set_req(2, 6'h09, 8'h99, 1'b1);
        set_req(0, 6'h03, 8'h44, 1'b0);
        expect_txn(0, 6'h03, 8'h44, 1'b0, 8'h10, 1'b0);
        expect_txn(2, 6'h09, 8'h99, 1'b1, 8'h10, 1'b0);
        clear_sends();
        drain("rr2");
        exp_last_rd = 8'h10;

        // Single write with a 20-cycle busy SPI master
        model_busy  = 20;
        model_rdata = 8'h3C;
        @(negedge clk);
        t0 = cyc;
        set_req(0, 6'h05, 8'h80, 1'b0);
        expect_txn(0, 6'h05, 8'h80, 1'b0, 8'h3C, 1'b0);
        clear_sends();
        wait_send(ts);
        check_eq("wr_send_latency", ts, t0 + 2);
        check_eq("wr_busy", 32'(o_req_busy), 32'h1);
        drain("wr");
        exp_last_rd = 8'h3C;

        // Read
        model_busy  = 6;
        model_rdata = 8'hA5;
        @(negedge clk);
        set_req(1, 6'h1F, 8'h00, 1'b1);
        expect_txn(1, 6'h1F, 8'h00, 1'b1, 8'hA5, 1'b0);
        clear_sends();
        drain("rd");
        check_eq("rd_data_hold", 32'(o_rd_data), 32'hA5);
        exp_last_rd = 8'hA5;

        // Overrun: second send 3 cycles later is dropped
        model_busy  = 10;
        model_rdata = 8'h77;
        @(negedge clk);
        set_req(2, 6'h0A, 8'h5A, 1'b0);
        expect_txn(2, 6'h0A, 8'h5A, 1'b0, 8'h77, 1'b0);
        clear_sends();
        repeat (2) @(negedge clk);
        set_req(2, 6'h0B, 8'hFF, 1'b0);
        clear_sends();
        check_eq("ovr_pulse", 32'(o_req_overrun), 32'h4);
        @(negedge clk);
        check_eq("ovr_single_cycle", 32'(o_req_overrun), 0);
        for (int k = 0; k < 100 && !o_req_done[2]; k++) @(negedge clk);
        check_eq("ovr_done_seen", 32'(o_req_done[2]), 1);
        // Send coinciding with the owner's done pulse
        set_req(2, 6'h0C, 8'h66, 1'b0);
        expect_txn(2, 6'h0C, 8'h66, 1'b0, 8'h77, 1'b0);
        clear_sends();
        drain("ovr");
        check_eq("ovr_count", ovr_total, 1);
        exp_last_rd = 8'h77;

        // Timeout: SPI master never responds
        model_dead = 1'b1;
        @(negedge clk);
        set_req(0, 6'h12, 8'h34, 1'b0);
        expect_txn(0, 6'h12, 8'h34, 1'b0, exp_last_rd, 1'b1);
        clear_sends();
        drain("tmo");
        check_eq("tmo_rd_unchanged", 32'(o_rd_data), 32'(exp_last_rd));
        model_dead = 1'b0;

        // Reset in WAIT_RISE abandons the transaction
        model_busy  = 30;
        model_rdata = 8'hEE;
        @(negedge clk);
        set_req(1, 6'h15, 8'h99, 1'b0);
        exp_issue.push_back({6'h15, 8'h99, 1'b0});
        clear_sends();
        wait_send(ts);
        repeat (4) @(negedge clk);
        check_eq("pre_rst_busy", 32'(o_req_busy), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_req_out", 32'({o_req_busy, o_req_done, o_req_overrun}), 0);
        check_eq("midrst_rd_data", 32'(o_rd_data), 0);
        check_eq("midrst_spi_out",
                 32'({o_spi_reg, o_spi_data_in, o_spi_rw, o_spi_send, o_spi_timeout}), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        exp_last_rd = 8'h00;

        // Clean transaction after reset
        model_busy  = 5;
        model_rdata = 8'hE1;
        @(negedge clk);
        t0 = cyc;
        set_req(2, 6'h2A, 8'hC3, 1'b1);
        expect_txn(2, 6'h2A, 8'hC3, 1'b1, 8'hE1, 1'b0);
        clear_sends();
        wait_send(ts);
        check_eq("post_rst_send_latency", ts, t0 + 2);
        drain("post_rst");
        check_eq("final_ovr_count", ovr_total, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cfg_arbiter.md
# spi_cfg_arbiter

Round-robin arbiter that shares the single DAC/peripheral SPI register-write master between several configuration requesters, e.g. the DAC bring-up sequencer, a host register port and a debug console. Each requester issues one-cycle send pulses with a 6-bit register address, 8-bit data and a read/write flag. The arbiter queues one transaction per requester, serialises them onto the SPI master and returns a per-requester completion pulse plus read data.

## Interface
- NUM_REQ, 3: number of requesters (2..8).
- DONE_TIMEOUT, 1024: cycles to wait for `spi_done` to fall after a send before aborting.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- req_send  input  NUM_REQ  per-requester one-cycle transaction request pulse.
- req_reg  input  6*NUM_REQ  register address; slice i = [6i+5:6i].
- req_data  input  8*NUM_REQ  write data; slice i = [8i+7:8i].
- req_rw  input  NUM_REQ  1 = read, 0 = write.
- req_busy  output  NUM_REQ  requester i has a pending or active transaction.
- req_done  output  NUM_REQ  one-cycle completion pulse to requester i.
- req_overrun  output  NUM_REQ  one-cycle pulse: send arrived while busy, dropped.
- rd_data  output  8  data from last completed transaction; valid with its req_done.
- spi_reg  output  6  address to SPI master.
- spi_data_in  output  8  write data to SPI master.
- spi_rw  output  1  read/write flag to SPI master.
- spi_send  output  1  one-cycle start pulse to SPI master.
- spi_done  input  1  SPI master idle/done level; high when idle, low while shifting.
- spi_data_out  input  8  read data from SPI master, valid when spi_done is high.
- spi_timeout  output  1  one-cycle pulse: a transaction was aborted by timeout.

## Operation
- Capture: per requester a pending bit plus held reg/data/rw. `req_send[i]` with pending[i]=0 sets pending and latches the inputs at that edge. With pending[i]=1 the send is dropped and `req_overrun[i]` pulses next cycle. `req_busy` = pending.
- Arbitration: round-robin. Search starts at (last_grant+1) mod NUM_REQ. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT_FALL, WAIT_RISE.
  - IDLE: if any pending, select the winner, load spi_reg/spi_data_in/spi_rw from its held copy, go to ISSUE.
  - ISSUE: assert spi_send for exactly one cycle, clear the timeout counter, go to WAIT_FALL.
  - WAIT_FALL: when spi_done=0, go to WAIT_RISE. If the counter reaches DONE_TIMEOUT-1, pulse spi_timeout and req_done[winner], clear pending[winner], leave rd_data unchanged, go to IDLE.
  - WAIT_RISE: when spi_done=1, capture spi_data_out into rd_data (write transactions too), pulse req_done[winner], clear pending[winner], update last_grant, go to IDLE. No timeout applies in this state.
- spi_reg/spi_data_in/spi_rw stay stable from ISSUE until the FSM re-enters IDLE.
- A send that arrives in the same cycle as its owner's clear (req_done edge) is accepted as a new transaction, not an overrun.
- Reset values: all outputs 0, all pending 0, FSM IDLE, rd_data 0. Reset mid-transaction abandons it with no req_done. The requester must reissue.

## Timing
- `req_send[i]` at cycle 0 with the arbiter idle: pending at 1, IDLE selects at 1, spi_send high in cycle 2 (ISSUE), WAIT_FALL from 3.
- Completion: spi_done seen high in WAIT_RISE at cycle n gives req_done and rd_data at n+1. The next grant's spi_send is at n+3 at the earliest.
- Minimum turnaround per transaction: 5 cycles plus SPI master busy time.
- req_done, req_overrun, spi_send and spi_timeout are registered single-cycle pulses.
- Only one bit of req_done is ever high.

## Test plan
- Single write: req 0 sends reg 0x05 data 0x80 rw 0. Expect spi_send 2 cycles later with those values. Model drops spi_done for 20 cycles. Expect req_done[0] one cycle after spi_done rises, req_busy[0] low.
- Round-robin: all three requesters send in the same cycle (reg 0x04/0x07/0x08). Expect grant order 0,1,2. Then reqs 0 and 2 resend while 1 is idle: expect order 2 before 0 is impossible; order follows last_grant=2, giving 0 then 2.
- Read: req 1 sends reg 0x1F rw 1. Model returns spi_data_out 0xA5. Expect rd_data 0xA5 together with req_done[1].
- Overrun: req 2 sends twice 3 cycles apart. Expect req_overrun[2] once and only the first data to reach spi_data_in. A send coinciding with req_done[2] is accepted.
- Timeout: the model never drops spi_done. With DONE_TIMEOUT=16, expect spi_timeout and req_done[0] 16 cycles after spi_send, and rd_data unchanged.
- Reset mid-transaction: assert reset during WAIT_RISE. Expect all outputs 0 next cycle, no req_done, and a clean transaction after release.
